// File: rtl/tx_uart.sv
// UART transmitter: serialises one byte per accepted request into a
// start / NB_DATA data (LSB first) / stop frame, timed by the baud tick.
module tx_uart #(
    parameter int NB_DATA         = 8,
    parameter int N_TICKS_PER_BIT = 16,
    parameter int N_STOP_TICKS    = 16,
    parameter int NB_COUNT        = 6,
    parameter int NB_DATA_COUNT   = 3
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_tx_done_tick,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [NB_COUNT-1:0]      LP_BIT_LAST  = NB_COUNT'(N_TICKS_PER_BIT - 1);
    localparam logic [NB_COUNT-1:0]      LP_STOP_LAST = NB_COUNT'(N_STOP_TICKS - 1);
    localparam logic [NB_DATA_COUNT-1:0] LP_DATA_LAST = NB_DATA_COUNT'(NB_DATA - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [NB_COUNT-1:0]      r_tick_cnt;
    logic [NB_COUNT-1:0]      w_tick_cnt_next;
    logic [NB_DATA_COUNT-1:0] r_bit_cnt;
    logic [NB_DATA_COUNT-1:0] w_bit_cnt_next;
    logic [NB_DATA-1:0]       r_shreg;
    logic [NB_DATA-1:0]       w_shreg_next;
    logic                     r_tx;
    logic                     w_tx_next;
    logic                     r_done;
    logic                     w_done_next;
    logic                     w_busy;

    // State register; the line and done pulse are registered alongside it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shreg    <= w_shreg_next;
            r_tx       <= w_tx_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_tick_cnt_next = r_tick_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_shreg_next    = r_shreg;
        case (r_state)
            IDLE: begin
                // A tick coinciding with acceptance is deliberately dropped.
                if (i_tx_start) begin
                    w_shreg_next    = i_data;
                    w_tick_cnt_next = '0;
                    w_state_next    = START;
                end
            end
            START: begin
                if (i_tick) begin
                    if (r_tick_cnt == LP_BIT_LAST) begin
                        w_tick_cnt_next = '0;
                        w_bit_cnt_next  = '0;
                        w_state_next    = DATA;
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + NB_COUNT'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (r_tick_cnt == LP_BIT_LAST) begin
                        w_tick_cnt_next = '0;
                        w_shreg_next    = r_shreg >> 1;
                        if (r_bit_cnt == LP_DATA_LAST) begin
                            w_state_next = STOP;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + NB_DATA_COUNT'(1);
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + NB_COUNT'(1);
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (r_tick_cnt == LP_STOP_LAST) begin
                        w_tick_cnt_next = '0;
                        w_state_next    = IDLE;
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + NB_COUNT'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so the pin moves with the state.
    always_comb begin
        w_tx_next   = 1'b1;
        w_done_next = 1'b0;
        w_busy      = (r_state != IDLE);
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shreg_next[0];
            default: w_tx_next = 1'b1;
        endcase
        if ((r_state == STOP) && i_tick && (r_tick_cnt == LP_STOP_LAST)) begin
            w_done_next = 1'b1;
        end
    end

    assign o_tx           = r_tx;
    assign o_tx_done_tick = r_done;
    assign o_busy         = w_busy;

endmodule

// File: tb/tb_tx_uart.sv
// Bench for tx_uart: directed frames, a behavioural loopback receiver feeding
// a byte scoreboard, plus a second instance built with a 32-tick stop period.
module tb_tx_uart;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       tick   = 1'b0;
    logic       start  = 1'b0;
    logic       start2 = 1'b0;
    logic [7:0] data   = 8'h00;
    logic [7:0] data2  = 8'h00;
    logic       tx, done, busy;
    logic       tx2, done2, busy2;

    int  n_chk = 0;
    int  n_pass = 0;
    int  tick_phase = 0;
    byte unsigned exp_q[$];

    // receiver / monitor state
    int         rs = 0, rcnt = 0, rbit = 0, rx_cnt = 0, done_cnt = 0;
    logic [7:0] rsh = 8'h00;
    bit         rx_on = 1'b1;

    tx_uart #(.NB_DATA(8), .N_TICKS_PER_BIT(16), .N_STOP_TICKS(16),
              .NB_COUNT(6), .NB_DATA_COUNT(3)) dut (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start),
        .i_data(data), .o_tx(tx), .o_tx_done_tick(done), .o_busy(busy));

    tx_uart #(.NB_DATA(8), .N_TICKS_PER_BIT(16), .N_STOP_TICKS(32),
              .NB_COUNT(6), .NB_DATA_COUNT(3)) dut2 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start2),
        .i_data(data2), .o_tx(tx2), .o_tx_done_tick(done2), .o_busy(busy2));

    // Tick changes between posedge and negedge so it is stable around both.
    initial begin
        forever begin
            #5 clk = 1'b1;
            #3 tick_phase = (tick_phase + 1) % 4;
            tick = (tick_phase == 0);
            #2 clk = 1'b0;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    // Loopback receiver: mid-bit sampling on tick counts, reports to scoreboard.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rx_on) begin
            rs = 0;
        end else begin
            if (rs == 0 && tx === 1'b0) begin
                rs = 1;
                rcnt = 0;
            end
            if (rs != 0 && tick) begin
                rcnt++;
                case (rs)
                    1: if (rcnt == 8) begin
                        rcnt = 0;
                        rbit = 0;
                        rs = (tx === 1'b0) ? 2 : 0;
                    end
                    2: if (rcnt == 16) begin
                        rcnt = 0;
                        rsh = {tx, rsh[7:1]};
                        rbit++;
                        if (rbit == 8) rs = 3;
                    end
                    3: if (rcnt == 16) begin
                        check("rx_stop_bit", {31'b0, tx}, 32'd1);
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            $error("FAIL rx_unexpected: got %02h, want no byte", rsh);
                        end else begin
                            check("rx_byte", {24'b0, rsh}, {24'b0, exp_q.pop_front()});
                        end
                        rx_cnt++;
                        rs = 0;
                    end
                    default: rs = 0;
                endcase
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, input bit expect_rx);
        data  = d;
        start = 1'b1;
        if (expect_rx) exp_q.push_back(d);
        @(negedge clk);
        start = 1'b0;
        data  = 8'($urandom);
    endtask

    task automatic wait_done(input int bound, output int nt, output bit ok);
        nt = 0;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (tick) nt++;
            @(negedge clk);
        end
    endtask

    // Returns at the negedge where the n-th tick is visible (not yet consumed).
    task automatic wait_ticks(input int n);
        int c;
        c = 0;
        for (int i = 0; i < 8 * n + 8; i++) begin
            if (tick) begin
                c++;
                if (c == n) break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int         nt, bad, k, dc;
        bit         ok;
        logic       lvl;
        logic [7:0] pat;

        repeat (3) @(negedge clk);
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        rst = 1'b0;

        // idle with no request
        nt = 0; bad = 0;
        for (int i = 0; i < 2000 && nt < 200; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
            if (tick) nt++;
            @(negedge clk);
        end
        check("idle_quiet", bad, 0);

        // 0x55: every tick checked against the expected line level
        pat = 8'h55;
        send(pat, 1'b1);
        check("start_latency_tx", {31'b0, tx}, 32'd0);
        check("start_latency_busy", {31'b0, busy}, 32'd1);
        k = 0; bad = 0;
        for (int i = 0; i < 2000; i++) begin
            if (done === 1'b1) break;
            if (tick) begin
                if (k < 16) lvl = 1'b0;
                else if (k < 144) lvl = pat[(k - 16) / 16];
                else lvl = 1'b1;
                if (tx !== lvl) bad++;
                if (k % 16 == 8) check($sformatf("p55_level%0d", k / 16), {31'b0, tx}, {31'b0, lvl});
                k++;
            end
            @(negedge clk);
        end
        check("p55_done_seen", {31'b0, done}, 32'd1);
        check("p55_frame_ticks", k, 160);
        check("p55_tick_levels", bad, 0);
        @(negedge clk);
        check("p55_done_width", {31'b0, done}, 32'd0);
        check("p55_idle_after", {31'b0, busy}, 32'd0);

        // loopback bytes
        foreach (exp_q[i]) begin end
        send(8'hA3, 1'b1); wait_done(1000, nt, ok); check("a3_done", {31'b0, ok}, 32'd1);
        @(negedge clk);
        send(8'h00, 1'b1); wait_done(1000, nt, ok); check("00_done", {31'b0, ok}, 32'd1);
        @(negedge clk);
        send(8'hFF, 1'b1); wait_done(1000, nt, ok); check("ff_frame_ticks", nt, 160);
        @(negedge clk);

        // request while busy is ignored
        dc = done_cnt;
        send(8'h81, 1'b1);
        wait_ticks(40);
        send(8'h3C, 1'b0);
        check("busy_ignore_busy", {31'b0, busy}, 32'd1);
        wait_done(1000, nt, ok);
        check("busy_81_done", {31'b0, ok}, 32'd1);
        wait_ticks(40);
        check("busy_no_restart", {31'b0, busy}, 32'd0);
        check("busy_one_done", done_cnt - dc, 1);

        // back-to-back: start in the done cycle
        send(8'h44, 1'b1);
        wait_done(1000, nt, ok);
        check("b2b_first_done", {31'b0, ok}, 32'd1);
        check("b2b_idle_in_done", {31'b0, busy}, 32'd0);
        send(8'h12, 1'b1);
        check("b2b_start_low", {31'b0, tx}, 32'd0);
        wait_done(1000, nt, ok);
        check("b2b_second_ticks", nt, 160);
        @(negedge clk);

        // reset in the middle of data bit 4 of 0xEF (bit 4 is 0)
        rx_on = 1'b0;
        dc = done_cnt;
        send(8'hEF, 1'b0);
        wait_ticks(88);
        check("pre_reset_low", {31'b0, tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_tx", {31'b0, tx}, 32'd1);
        check("midreset_busy", {31'b0, busy}, 32'd0);
        nt = 0; bad = 0;
        for (int i = 0; i < 1000 && nt < 100; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
            if (tick) nt++;
            @(negedge clk);
        end
        check("midreset_quiet", bad, 0);
        check("midreset_no_done", done_cnt - dc, 0);

        // reset and start together: reset wins
        rst = 1'b1; start = 1'b1; data = 8'h99;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_vs_start_busy", {31'b0, busy}, 32'd0);
        check("rst_vs_start_tx", {31'b0, tx}, 32'd1);
        @(negedge clk);
        rx_on = 1'b1;
        @(negedge clk);
        send(8'h7E, 1'b1);
        wait_done(1000, nt, ok);
        check("after_reset_ticks", nt, 160);
        @(negedge clk);

        // 32-tick stop period instance
        data2 = 8'h5A; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        k = 0; bad = 0;
        for (int i = 0; i < 2000; i++) begin
            if (done2 === 1'b1) break;
            if (tick) begin
                if (k >= 144 && tx2 !== 1'b1) bad++;
                if (k < 16 && tx2 !== 1'b0) bad++;
                k++;
            end
            @(negedge clk);
        end
        check("stop32_done_seen", {31'b0, done2}, 32'd1);
        check("stop32_frame_ticks", k, 176);
        check("stop32_levels", bad, 0);
        @(negedge clk);
        check("stop32_done_width", {31'b0, done2}, 32'd0);

        repeat (10) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        check("rx_count", rx_cnt, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
